// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB first over WIDTH cycles using two
// half-subtractor cells per cycle and a registered borrow between bit slices.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both 1; ready/valid here depend only on registered state, and a
    // producer must hold its payload stable while valid is high and ready low.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
    logic [CW-1:0]    cnt;
    logic             br_ff;
    logic             x, y, d1, b1, d, b2;

    // Two cascaded half subtractors: (x - y), then (d1 - incoming borrow).
    always_comb begin
        x  = a_sr[0];
        y  = b_sr[0];
        d1 = x ^ y;
        b1 = ~x & y;
        d  = d1 ^ br_ff;
        b2 = ~d1 & br_ff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Result bits enter at the MSB so that after WIDTH shifts bit 0 is the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            cnt     <= '0;
            br_ff   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br_ff <= 1'b0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    diff_sr <= {d, diff_sr[WIDTH-1:1]};
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    br_ff   <= b1 | b2;
                    cnt     <= cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign diff      = diff_sr;
    assign borrow    = br_ff;
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed checks of serial_subtractor at WIDTH=8, plus an exhaustive WIDTH=4
// sweep with random handshake gaps scored against an expected queue.
module tb_serial_subtractor;

    localparam int W8 = 8;
    localparam int W4 = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, borrow;
    logic [W8-1:0] a, b, diff;
    logic [1:0]    dbg_state;

    logic          in_valid4, in_ready4, out_valid4, out_ready4, borrow4;
    logic [W4-1:0] a4, b4, diff4;
    logic [1:0]    dbg_state4;

    int total = 0;
    int bad   = 0;

    logic [W4:0] exp_q[$];

    // clock / reset block
    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow), .dbg_state(dbg_state)
    );

    serial_subtractor #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .diff(diff4), .borrow(borrow4), .dbg_state(dbg_state4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one 8-bit operation, hold the result for 'hold' cycles, then drain it.
    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] ed, input logic eb, input int hold);
        int   n;
        logic early;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check({tag, " idle_ready"}, 32'(in_ready), 32'd1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        tick();
        // Operands and in_valid wiggle during SHIFT; none of it may matter.
        a = ~av;
        b = ~bv;
        check({tag, " busy_ready"}, 32'(in_ready), 32'd0);
        early = 1'b0;
        for (int i = 1; i < W8; i++) begin
            tick();
            if (out_valid) early = 1'b1;
        end
        in_valid = 1'b0;
        check({tag, " no_early_valid"}, 32'(early), 32'd0);
        tick();
        check({tag, " valid_at_width"}, 32'(out_valid), 32'd1);
        check({tag, " diff"}, 32'(diff), 32'(ed));
        check({tag, " borrow"}, 32'(borrow), 32'(eb));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold_diff"}, 32'(diff), 32'(ed));
            check({tag, " hold_borrow"}, 32'(borrow), 32'(eb));
            check({tag, " hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " drained_valid"}, 32'(out_valid), 32'd0);
        check({tag, " drained_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        a4         = '0;
        b4         = '0;

        // reset state
        tick();
        tick();
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst diff", 32'(diff), 32'd0);
        check("rst borrow", 32'(borrow), 32'd0);
        rst = 1'b0;

        // directed arithmetic
        op8("5-3",   8'h05, 8'h03, 8'h02, 1'b0, 0);
        op8("3-5",   8'h03, 8'h05, 8'hFE, 1'b1, 0);
        op8("0-1",   8'h00, 8'h01, 8'hFF, 1'b1, 0);
        op8("FF-FF", 8'hFF, 8'hFF, 8'h00, 1'b0, 0);
        op8("80-0",  8'h80, 8'h00, 8'h80, 1'b0, 0);

        // backpressure in DONE
        op8("bp 9A-3C", 8'h9A, 8'h3C, 8'h5E, 1'b0, 5);

        // reset during the third SHIFT cycle
        a = 8'h12;
        b = 8'h34;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst diff", 32'(diff), 32'd0);
        check("midrst borrow", 32'(borrow), 32'd0);
        op8("post-rst 10-01", 8'h10, 8'h01, 8'h0F, 1'b0, 0);

        // WIDTH=4 exhaustive sweep with random gaps
        fork
            begin : producer
                logic [3:0] av, bv;
                logic       hs;
                int         n;
                for (int i = 0; i < 256; i++) begin
                    av = 4'(i >> 4);
                    bv = 4'(i);
                    for (int g = $urandom_range(0, 3); g > 0; g--) tick();
                    a4 = av;
                    b4 = bv;
                    in_valid4 = 1'b1;
                    exp_q.push_back({(av < bv) ? 1'b1 : 1'b0, 4'(av - bv)});
                    n = 0;
                    do begin
                        hs = in_ready4;
                        tick();
                        n++;
                    end while (!hs && n < 200);
                    if (!hs) check("w4 accept_timeout", 32'd0, 32'd1);
                    in_valid4 = 1'b0;
                end
            end
            begin : consumer
                int          got;
                int          guard;
                logic [W4:0] e;
                got   = 0;
                guard = 0;
                while (got < 256 && guard < 20000) begin
                    out_ready4 = ($urandom_range(0, 2) != 0);
                    if (out_valid4 && out_ready4) begin
                        if (exp_q.size() == 0) begin
                            check("w4 unexpected_result", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("w4 result", 32'({borrow4, diff4}), 32'(e));
                        end
                        got++;
                    end
                    tick();
                    guard++;
                end
                out_ready4 = 1'b0;
                check("w4 result_count", 32'(got), 32'd256);
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
